// File: rtl/cache_wb_ctrl_if.sv
// RAM-side req/ack bus of the write-back cache controller.
// The master drives a transfer request; the slave answers with ack and read data.
interface cache_wb_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
);
    logic             RAM_req;
    logic             RAM_we;
    logic [AW-1:0]    RAM_addr;
    logic [WIDTH-1:0] RAM_data_out;
    logic [WIDTH-1:0] RAM_data_in;
    logic             RAM_ack;

    modport master (
        output RAM_req, RAM_we, RAM_addr, RAM_data_out,
        input  RAM_data_in, RAM_ack
    );

    modport slave (
        input  RAM_req, RAM_we, RAM_addr, RAM_data_out,
        output RAM_data_in, RAM_ack
    );
endinterface

// File: rtl/cache_wb_ctrl.sv
// Set-associative write-back cache controller: multi-word lines, LRU replacement, req/ack RAM bus.
// Define CACHE_STATS_EN to add saturating hit/miss/writeback counters as outputs.
module cache_wb_ctrl #(
    parameter int WIDTH      = 8,
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 32,
    parameter int LINE_WORDS = 2,
    parameter int RAM_DEPTH  = 256,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    cache_wb_ctrl_if.master  ram
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count,
    output logic [15:0]      wb_count
`endif
);

    localparam int SETS  = TOTAL_SIZE / (WAYS * LINE_WORDS);
    localparam int OFF_B = $clog2(LINE_WORDS);
    localparam int IDX_B = $clog2(SETS);
    localparam int OFF_W = (OFF_B > 0) ? OFF_B : 1;
    localparam int IDX_W = (IDX_B > 0) ? IDX_B : 1;
    localparam int TAG_W = AW - OFF_B - IDX_B;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t           state;
    logic [AW-1:0]    req_addr;
    logic             req_write;
    logic [WIDTH-1:0] req_data;
    logic [WAY_W-1:0] way_q;
    logic [OFF_W-1:0] cnt;

    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [WIDTH-1:0] data_mem [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0]  valid    [SETS];
    logic [WAYS-1:0]  dirty    [SETS];
    logic [WAY_W-1:0] age      [SETS][WAYS];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] next_cnt;
    logic             last_word;
    logic             xfer_ack;
    logic             fill_we;
    logic             hit_we;

    assign req_off   = OFF_W'(req_addr % AW'(LINE_WORDS));
    assign req_idx   = IDX_W'((req_addr >> OFF_B) % AW'(SETS));
    assign req_tag   = TAG_W'(req_addr >> (OFF_B + IDX_B));
    assign next_cnt  = cnt + 1'b1;
    assign last_word = (cnt == OFF_W'(LINE_WORDS - 1));
    assign xfer_ack  = ram.RAM_req && ram.RAM_ack;
    assign fill_we   = !rst && state == REFILL && xfer_ack;
    assign hit_we    = !rst && state == RESPOND && req_write;
    assign ready     = (state == IDLE);

    function automatic logic [AW-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                input logic [IDX_W-1:0] i,
                                                input logic [OFF_W-1:0] o);
        return (AW'(t) << (OFF_B + IDX_B)) | (AW'(i) << OFF_B) | AW'(o);
    endfunction

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scans leave the lowest-numbered match; invalid ways take priority over LRU.
        for (int w = WAYS - 1; w >= 0; w--)
            if (age[req_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[req_idx][w]) victim = WAY_W'(w);
    end

    // NOTE: tag and data arrays have no reset; they are only observed once the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_we) data_mem[way_q][req_idx][cnt] <= ram.RAM_data_in;
        if (fill_we && last_word) tag_mem[way_q][req_idx] <= req_tag;
        if (hit_we) data_mem[way_q][req_idx][req_off] <= req_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            done             <= 1'b0;
            data_out         <= '0;
            ram.RAM_req      <= 1'b0;
            ram.RAM_we       <= 1'b0;
            ram.RAM_addr     <= '0;
            ram.RAM_data_out <= '0;
            req_addr         <= '0;
            req_write        <= 1'b0;
            req_data         <= '0;
            way_q            <= '0;
            cnt              <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
            end
`ifdef CACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (re || we) begin
                    req_addr  <= addr;
                    req_write <= we;
                    req_data  <= data_in;
                    state     <= LOOKUP;
                end
                LOOKUP: begin
                    cnt <= '0;
                    if (hit) begin
                        way_q <= hit_way;
                        state <= RESPOND;
`ifdef CACHE_STATS_EN
                        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
`endif
                    end else begin
                        way_q <= victim;
`ifdef CACHE_STATS_EN
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        if (valid[req_idx][victim] && dirty[req_idx][victim] && wb_count != 16'hFFFF)
                            wb_count <= wb_count + 16'd1;
`endif
                        if (valid[req_idx][victim] && dirty[req_idx][victim]) state <= WRITEBACK;
                        else state <= REFILL;
                    end
                end
                WRITEBACK: begin
                    if (!ram.RAM_req) begin
                        ram.RAM_req      <= 1'b1;
                        ram.RAM_we       <= 1'b1;
                        ram.RAM_addr     <= line_addr(tag_mem[way_q][req_idx], req_idx, cnt);
                        ram.RAM_data_out <= data_mem[way_q][req_idx][cnt];
                    end else if (ram.RAM_ack) begin
                        if (last_word) begin
                            ram.RAM_req <= 1'b0;
                            cnt         <= '0;
                            state       <= REFILL;
                        end else begin
                            cnt              <= next_cnt;
                            ram.RAM_addr     <= line_addr(tag_mem[way_q][req_idx], req_idx, next_cnt);
                            ram.RAM_data_out <= data_mem[way_q][req_idx][next_cnt];
                        end
                    end
                end
                REFILL: begin
                    if (!ram.RAM_req) begin
                        ram.RAM_req  <= 1'b1;
                        ram.RAM_we   <= 1'b0;
                        ram.RAM_addr <= line_addr(req_tag, req_idx, cnt);
                    end else if (ram.RAM_ack) begin
                        if (last_word) begin
                            ram.RAM_req           <= 1'b0;
                            valid[req_idx][way_q] <= 1'b1;
                            dirty[req_idx][way_q] <= 1'b0;
                            state                 <= RESPOND;
                        end else begin
                            cnt          <= next_cnt;
                            ram.RAM_addr <= line_addr(req_tag, req_idx, next_cnt);
                        end
                    end
                end
                RESPOND: begin
                    done <= 1'b1;
                    if (req_write) dirty[req_idx][way_q] <= 1'b1;
                    else data_out <= data_mem[way_q][req_idx][req_off];
                    for (int w = 0; w < WAYS; w++)
                        if (age[req_idx][w] < age[req_idx][way_q])
                            age[req_idx][w] <= age[req_idx][w] + 1'b1;
                    age[req_idx][way_q] <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
